// File: rtl/ttl_prog_updown_counter_if.sv
// Pin bundle for the programmable up/down counter: load/enable/direction controls in,
// count, terminal-count, cascade carry and one-shot flag out.
interface ttl_prog_updown_counter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  PE_n;
  logic                  LM_n;
  logic                  U_D;
  logic                  CEP_n;
  logic                  CET_n;
  logic [1:0]            MODE;
  logic [DATA_WIDTH-1:0] P;
  logic [DATA_WIDTH-1:0] Q;
  logic                  TC_n;
  logic                  RCO_n;
  logic                  DONE;

  modport master (
    output PE_n, LM_n, U_D, CEP_n, CET_n, MODE, P,
    input  Q, TC_n, RCO_n, DONE
  );

  modport slave (
    input  PE_n, LM_n, U_D, CEP_n, CET_n, MODE, P,
    output Q, TC_n, RCO_n, DONE
  );
endinterface

// File: rtl/ttl_prog_updown_counter.sv
// TTL-style synchronous up/down counter with a programmable limit register,
// wrap/saturate/one-shot terminal behaviour and CET_n/RCO_n cascading.
module ttl_prog_updown_counter #(
  parameter int DATA_WIDTH = 8
) (
  input logic                        clk,
  input logic                        rst,
  ttl_prog_updown_counter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0]            MODE_SAT     = 2'b01;
  localparam logic [1:0]            MODE_ONESHOT = 2'b10;
  localparam logic [DATA_WIDTH-1:0] ONE          = DATA_WIDTH'(1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic [DATA_WIDTH-1:0] m_q, m_d;
  logic                  done_q, done_d;
  logic                  en;
  logic                  tc;
  logic                  one_shot;
  logic                  count_ok;

  assign en       = bus.PE_n & ~bus.CEP_n & ~bus.CET_n;
  assign one_shot = (bus.MODE == MODE_ONESHOT);
  // A preloaded value above the limit counts as terminal when counting up.
  assign tc       = bus.U_D ? (q_q >= m_q) : (q_q == '0);

  assign bus.Q     = q_q;
  assign bus.TC_n  = ~tc;
  assign bus.RCO_n = ~(tc & ~bus.CET_n);
  assign bus.DONE  = done_q;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= '0;
      m_q     <= '1;
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      m_q     <= m_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (!one_shot) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (!bus.PE_n) state_d = S_RUN;
        S_RUN:   if (en && tc) state_d = S_DONE;
        S_DONE:  if (!bus.PE_n) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    count_ok = !one_shot || (state_q == S_RUN);
    done_d   = (state_d == S_DONE);
  end

  always_comb begin
    q_d = q_q;
    m_d = m_q;
    if (!bus.LM_n) m_d = bus.P;
    if (!bus.PE_n) begin
      q_d = bus.P;
    end else if (en && count_ok) begin
      if (!tc) begin
        q_d = bus.U_D ? q_q + ONE : q_q - ONE;
      end else begin
        case (bus.MODE)
          MODE_SAT, MODE_ONESHOT: q_d = q_q;
          default:                q_d = bus.U_D ? '0 : m_q;
        endcase
      end
    end
  end

endmodule
